anjian_kongzhi: RTL
===================

// Module: anjian_kongzhi
// PURPOSE
//   Upstream control stage for the 6-digit BCD counter/display chain. Debounces two
//   active-low pushbuttons (start/pause, clear), runs an IDLE/RUN/PAUSE state machine,
//   and produces the 1-cycle count-enable tick feeding the first BCD counter stage.
//   Also produces a 1-cycle clear pulse that zeroes the counter chain.
// PARAMETERS
//   TICK_DIV    50_000_000  clk cycles per tick_out pulse (1 Hz at 50 MHz); >= 2
//   DEB_CYCLES  1_000_000   cycles a key level must stay stable to be accepted (20 ms); >= 2
//   LONG_CYCLES 100_000_000 hold time for long-press clear (used only with KEY_LONGPRESS_EN)
// PORTS
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   key_start_n  in   1  start/pause button, low = pressed, asynchronous to clk
//   key_clear_n  in   1  clear button, low = pressed, asynchronous to clk
//   tick_out     out  1  1-cycle count-enable pulse to counter chain
//   clr_out      out  1  1-cycle clear pulse to counter chain
//   run          out  1  high while in RUN
// BEHAVIOUR
//   Reset (async, rst_n=0): tick_out=0, clr_out=0, run=0; state=IDLE; divider=0;
//     debounced key levels=1 (released); debounce counters=0. Applies immediately, mid-count included.
//   Sync: each key passes a 2-FF synchronizer before any other logic.
//   Debounce per key: counter clears whenever synced level == stable level; else increments;
//     at DEB_CYCLES-1, stable level takes synced level and counter clears. Glitch shorter than
//     DEB_CYCLES cycles -> no change. Press event = stable 1->0, exactly one cycle; release
//     produces no event; holding produces no further events.
//   FSM (events registered, all outputs registered):
//     IDLE  --start--> RUN
//     RUN   --start--> PAUSE
//     PAUSE --start--> RUN
//     any   --clear--> IDLE, clr_out=1 for one cycle (also issued when already IDLE)
//     start and clear events in same cycle: clear wins -> IDLE, start ignored.
//   Divider: 0..TICK_DIV-1, advances only in RUN; at TICK_DIV-1 wraps to 0 and tick_out=1
//     next cycle for exactly one cycle. PAUSE holds divider value (fraction kept on resume);
//     IDLE forces divider to 0. First tick after IDLE->RUN: exactly TICK_DIV cycles after run rises.
//   tick_out and clr_out never high in same cycle; tick_out never high while run=0,
//     except a tick already in flight in the cycle run falls is suppressed.
//   Latency: key pin stable low -> run/clr_out change within DEB_CYCLES+4 cycles.
// CONFIGURATION
//   KEY_LONGPRESS_EN defined: start key held (debounced low) for LONG_CYCLES cycles after its
//     press event generates one internal clear event (-> IDLE, clr_out pulse), once per press;
//     the initial press toggle still occurs. Counter resets on release.
//   KEY_LONGPRESS_EN undefined: no long-press logic, LONG_CYCLES ignored; holding start has
//     no effect beyond the single press event.
// TESTING (bench params: DEB_CYCLES=4, TICK_DIV=10, LONG_CYCLES=30)
//   Reset: rst_n=0 for 3 cycles -> tick_out=0, clr_out=0, run=0; no tick over 50 cycles.
//   Start: key_start_n low 20 cycles -> run=1 within 8 cycles; tick_out pulses every 10 cycles,
//     each 1 cycle wide; release -> no state change.
//   Bounce: key_start_n low pulses of 1-3 cycles for 40 cycles -> run stays 0, no events.
//   Pause/resume: start, run 15 cycles, start again -> run=0, no ticks; start again -> next
//     tick arrives 5 cycles after run rises (fraction held).
//   Clear: both keys pressed same cycle while RUN -> one clr_out pulse, run=0, divider=0,
//     first tick after next start exactly 10 cycles after run rises.
//   Long press (KEY_LONGPRESS_EN): from IDLE hold start 60 cycles -> run=1, then one clr_out
//     pulse ~30 cycles after press event, run=0; no second pulse. Macro undefined: run stays 1.
//   Async reset mid-RUN: rst_n low for 1 cycle -> outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/anjian_kongzhi.sv
// Key control front end for the 6-digit BCD counter chain: synchronises and debounces the
// start/clear buttons, runs IDLE/RUN/PAUSE and emits the count tick and clear pulse.
// Optional build macro KEY_LONGPRESS_EN adds a long-press-on-start clear.
module anjian_kongzhi #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int LONG_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_start_n,
    input  logic key_clear_n,
    output logic tick_out,
    output logic clr_out,
    output logic run
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int DEB_W = $clog2(DEB_CYCLES);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    if (TICK_DIV < 2 || DEB_CYCLES < 2 || LONG_CYCLES < 1) begin : g_param_check
        $error("anjian_kongzhi: TICK_DIV and DEB_CYCLES must be >= 2, LONG_CYCLES >= 1");
    end

    function automatic logic [DIV_W-1:0] div_step(input logic [DIV_W-1:0] d);
        return (d == DIV_MAX) ? '0 : d + DIV_W'(1);
    endfunction

    // Bit 0 carries the start key, bit 1 the clear key throughout the key path.
    logic [1:0]       key_sync_p0;
    logic [1:0]       key_sync_p1;
    logic [1:0]       key_stable_p2;
    logic [1:0]       key_press_p2;
    logic [DEB_W-1:0] deb_cnt_p2 [2];
    logic             clr_ev_p2;

    logic [1:0]       state_p3;
    logic [1:0]       state_nxt;
    logic [DIV_W-1:0] div_p3;

    // Stage p0/p1: two-flop synchroniser, idle level is released (1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_sync_p0 <= 2'b11;
            key_sync_p1 <= 2'b11;
        end else begin
            key_sync_p0 <= {key_clear_n, key_start_n};
            key_sync_p1 <= key_sync_p0;
        end
    end

    // Stage p2: debounce, a level must persist DEB_CYCLES samples; press = stable 1->0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_stable_p2 <= 2'b11;
            key_press_p2  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_p2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                key_press_p2[i] <= 1'b0;
                if (key_sync_p1[i] == key_stable_p2[i]) begin
                    deb_cnt_p2[i] <= '0;
                end else if (deb_cnt_p2[i] == DEB_MAX) begin
                    deb_cnt_p2[i]    <= '0;
                    key_stable_p2[i] <= key_sync_p1[i];
                    key_press_p2[i]  <= ~key_sync_p1[i];
                end else begin
                    deb_cnt_p2[i] <= deb_cnt_p2[i] + DEB_W'(1);
                end
            end
        end
    end

`ifdef KEY_LONGPRESS_EN
    localparam int LP_W = $clog2(LONG_CYCLES + 1);
    localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_CYCLES - 1);

    logic [LP_W-1:0] lp_cnt_p2;
    logic            lp_done_p2;
    logic            lp_clr_p2;

    // Counts cycles the debounced start key stays low; fires once per press, rearms on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_cnt_p2  <= '0;
            lp_done_p2 <= 1'b0;
            lp_clr_p2  <= 1'b0;
        end else begin
            lp_clr_p2 <= 1'b0;
            if (key_stable_p2[0]) begin
                lp_cnt_p2  <= '0;
                lp_done_p2 <= 1'b0;
            end else if (!lp_done_p2) begin
                if (lp_cnt_p2 == LP_MAX) begin
                    lp_cnt_p2  <= '0;
                    lp_done_p2 <= 1'b1;
                    lp_clr_p2  <= 1'b1;
                end else begin
                    lp_cnt_p2 <= lp_cnt_p2 + LP_W'(1);
                end
            end
        end
    end

    assign clr_ev_p2 = key_press_p2[1] | lp_clr_p2;
`else
    assign clr_ev_p2 = key_press_p2[1];
`endif

    always_comb begin
        state_nxt = state_p3;
        if (clr_ev_p2) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_p3)
                ST_IDLE:  if (key_press_p2[0]) state_nxt = ST_RUN;
                ST_RUN:   if (key_press_p2[0]) state_nxt = ST_PAUSE;
                ST_PAUSE: if (key_press_p2[0]) state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Stage p3: state, divider and registered outputs; a tick due as RUN is left is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p3 <= ST_IDLE;
            div_p3   <= '0;
            run      <= 1'b0;
            tick_out <= 1'b0;
            clr_out  <= 1'b0;
        end else begin
            state_p3 <= state_nxt;
            run      <= (state_nxt == ST_RUN);
            clr_out  <= clr_ev_p2;
            tick_out <= (state_p3 == ST_RUN) && (state_nxt == ST_RUN) && (div_p3 == DIV_MAX);
            if (state_nxt == ST_IDLE) begin
                div_p3 <= '0;
            end else if (state_p3 == ST_RUN) begin
                div_p3 <= div_step(div_p3);
            end
        end
    end

endmodule
